id_ex_register: RTL and testbench

//  ID/EX pipeline latch with integrated load-use hazard control. Captures the decoded

---
 rtl/id_ex_register_pkg.sv | 30 +++
 rtl/id_ex_register_load_use_detector.sv | 68 ++++++
 rtl/id_ex_register.sv | 125 ++++++++++++
 tb/tb_id_ex_register.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_register_pkg.sv
// Shared definitions for the ID/EX pipeline latch: default sizes, control
// bundle bit positions and load-use FSM state codes.
package id_ex_register_pkg;

  // Default geometry of the ID/EX latch.
  localparam int DEF_DATA_SIZE       = 32;
  localparam int DEF_ADDR_SIZE       = 5;
  localparam int DEF_CTRL_SIZE       = 10;
  localparam int DEF_CNT_SIZE        = 16;
  localparam int DEF_LOAD_USE_STALLS = 1;

  // Down-counter width; large enough for up to 7 bubbles per hazard.
  localparam int STALL_CNT_W = 3;

  // Bit positions inside the decoded control bundle.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 6;
  localparam int CTRL_ALU_OP_LO  = 7;
  localparam int CTRL_ALU_OP_HI  = 9;

  // Load-use FSM state codes.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/id_ex_register_load_use_detector.sv
// Load-use hazard detection for the ID/EX stage: compares the load held in EX
// against the sources of the instruction in ID, and sequences the bubbles.
module load_use_detector
  import id_ex_register_pkg::*;
#(
  parameter int ADDR_SIZE       = DEF_ADDR_SIZE,
  parameter int LOAD_USE_STALLS = DEF_LOAD_USE_STALLS
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic                 i_ex_mem_read,
  input  logic [ADDR_SIZE-1:0] i_ex_rt,
  input  logic [ADDR_SIZE-1:0] i_id_rs,
  input  logic [ADDR_SIZE-1:0] i_id_rt,
  input  logic                 i_id_uses_rt,
  output logic                 o_stall
);

  logic [0:0]             state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   hazard;

  // A load into $zero never produces a usable value, so it cannot cause a stall.
  assign hazard = i_ex_mem_read && (i_ex_rt != '0) &&
                  ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  // Stall request: fresh hazard in RUN or remaining bubbles in STALL; a flush wins.
  assign o_stall = i_enable && !i_flush &&
                   (((state_q == ST_RUN) && hazard) || (state_q == ST_STALL));

  // Next-state and down-counter; the first stall cycle is spent in RUN.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_enable) begin
      if (i_flush) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else if (state_q == ST_RUN) begin
        if (hazard && (LOAD_USE_STALLS > 1)) begin
          state_d = ST_STALL;
          cnt_d   = STALL_CNT_W'(LOAD_USE_STALLS - 1);
        end
      end else begin
        cnt_d = cnt_q - STALL_CNT_W'(1);
        if (cnt_q == STALL_CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // FSM state and remaining-bubble counter.
  always_ff @(posedge i_clock or negedge i_reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline latch: carries the decoded control bundle, register fields,
// immediate and PC+4 into EX, inserting bubbles on load-use hazards and flushes.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_SIZE       = DEF_DATA_SIZE,
  parameter int ADDR_SIZE       = DEF_ADDR_SIZE,
  parameter int CTRL_SIZE       = DEF_CTRL_SIZE,
  parameter int LOAD_USE_STALLS = DEF_LOAD_USE_STALLS,
  parameter int CNT_SIZE        = DEF_CNT_SIZE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic [CTRL_SIZE-1:0] i_ctrl,
  input  logic [ADDR_SIZE-1:0] i_rs,
  input  logic [ADDR_SIZE-1:0] i_rt,
  input  logic [ADDR_SIZE-1:0] i_rd,
  input  logic                 i_uses_rt,
  input  logic [DATA_SIZE-1:0] i_imm_ext,
  input  logic [DATA_SIZE-1:0] i_pc_plus4,
  output logic [CTRL_SIZE-1:0] o_ctrl,
  output logic [ADDR_SIZE-1:0] o_rs,
  output logic [ADDR_SIZE-1:0] o_rt,
  output logic [ADDR_SIZE-1:0] o_rd,
  output logic [DATA_SIZE-1:0] o_imm_ext,
  output logic [DATA_SIZE-1:0] o_pc_plus4,
  output logic                 o_stall,
  output logic [CNT_SIZE-1:0]  o_stall_count
);

  logic [CTRL_SIZE-1:0] ctrl_q, ctrl_d;
  logic [ADDR_SIZE-1:0] rs_q, rs_d;
  logic [ADDR_SIZE-1:0] rt_q, rt_d;
  logic [ADDR_SIZE-1:0] rd_q, rd_d;
  logic [DATA_SIZE-1:0] imm_ext_q, imm_ext_d;
  logic [DATA_SIZE-1:0] pc_plus4_q, pc_plus4_d;
  logic [CNT_SIZE-1:0]  stall_count_q, stall_count_d;
  logic                 stall;

  load_use_detector #(
    .ADDR_SIZE       (ADDR_SIZE),
    .LOAD_USE_STALLS (LOAD_USE_STALLS)
  ) u_load_use_detector (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_flush       (i_flush),
    .i_ex_mem_read (ctrl_q[CTRL_MEM_READ]),
    .i_ex_rt       (rt_q),
    .i_id_rs       (i_rs),
    .i_id_rt       (i_rt),
    .i_id_uses_rt  (i_uses_rt),
    .o_stall       (stall)
  );

  // Capture priority: flush clears everything, stall inserts a bubble, else pass ID through.
  always_comb begin
    ctrl_d     = ctrl_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    imm_ext_d  = imm_ext_q;
    pc_plus4_d = pc_plus4_q;
    if (i_enable) begin
      if (i_flush) begin
        ctrl_d     = '0;
        rs_d       = '0;
        rt_d       = '0;
        rd_d       = '0;
        imm_ext_d  = '0;
        pc_plus4_d = '0;
      end else if (stall) begin
        ctrl_d = '0;
      end else begin
        ctrl_d     = i_ctrl;
        rs_d       = i_rs;
        rt_d       = i_rt;
        rd_d       = i_rd;
        imm_ext_d  = i_imm_ext;
        pc_plus4_d = i_pc_plus4;
      end
    end
  end

  // Saturating count of stall cycles; the stall already implies the stage is enabled.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_SIZE'(1);
    end
  end

  // Pipeline latch and stall counter registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q        <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      imm_ext_q     <= '0;
      pc_plus4_q    <= '0;
      stall_count_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rd_q          <= rd_d;
      imm_ext_q     <= imm_ext_d;
      pc_plus4_q    <= pc_plus4_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign o_ctrl        = ctrl_q;
  assign o_rs          = rs_q;
  assign o_rt          = rt_q;
  assign o_rd          = rd_q;
  assign o_imm_ext     = imm_ext_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_stall       = stall;
  assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: dut_a uses one bubble per hazard with a 16-bit
// counter, dut_b uses three bubbles with a 2-bit counter to reach saturation.
module tb_id_ex_register;

  localparam logic [9:0] LW  = 10'h00B;  // reg_write | mem_to_reg | mem_read
  localparam logic [9:0] ADD = 10'h241;  // reg_write | reg_dst | alu_op

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable, i_flush, i_uses_rt;
  logic [9:0]  i_ctrl;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [31:0] i_imm_ext, i_pc_plus4;

  logic [9:0]  a_ctrl, b_ctrl;
  logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
  logic [31:0] a_imm, a_pc, b_imm, b_pc;
  logic        a_stall, b_stall;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  wire [88:0] a_bus = {a_ctrl, a_rs, a_rt, a_rd, a_imm, a_pc};
  wire [88:0] b_bus = {b_ctrl, b_rs, b_rt, b_rd, b_imm, b_pc};

  int total = 0;
  int bad   = 0;
  logic [88:0] exp_q[$];
  logic [88:0] exp_v;

  always #5 i_clock = ~i_clock;

  id_ex_register #(.LOAD_USE_STALLS(1), .CNT_SIZE(16)) dut_a (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_ctrl(i_ctrl), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_uses_rt(i_uses_rt),
    .i_imm_ext(i_imm_ext), .i_pc_plus4(i_pc_plus4),
    .o_ctrl(a_ctrl), .o_rs(a_rs), .o_rt(a_rt), .o_rd(a_rd), .o_imm_ext(a_imm),
    .o_pc_plus4(a_pc), .o_stall(a_stall), .o_stall_count(a_cnt)
  );

  id_ex_register #(.LOAD_USE_STALLS(3), .CNT_SIZE(2)) dut_b (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_ctrl(i_ctrl), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_uses_rt(i_uses_rt),
    .i_imm_ext(i_imm_ext), .i_pc_plus4(i_pc_plus4),
    .o_ctrl(b_ctrl), .o_rs(b_rs), .o_rt(b_rt), .o_rd(b_rd), .o_imm_ext(b_imm),
    .o_pc_plus4(b_pc), .o_stall(b_stall), .o_stall_count(b_cnt)
  );

  function automatic logic [88:0] mk(input logic [9:0] c, input logic [4:0] rs, rt, rd,
                                     input logic [31:0] imm, pc);
    return {c, rs, rt, rd, imm, pc};
  endfunction

  task automatic drive(input logic [9:0] c, input logic [4:0] rs, rt, rd,
                       input logic uses, input logic [31:0] imm, pc);
    i_ctrl = c; i_rs = rs; i_rt = rt; i_rd = rd;
    i_uses_rt = uses; i_imm_ext = imm; i_pc_plus4 = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic apply_reset();
    i_enable = 1'b1; i_flush = 1'b0;
    drive(10'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
  endtask

  // lw $5 with rs=1 sitting in EX, followed by a consumer of $5 in ID.
  task automatic load_lw5();
    drive(LW, 5'd1, 5'd5, 5'd0, 1'b0, 32'h10, 32'h100);
    tick();
  endtask

  task automatic test_reset();
    i_enable = 1'b1; i_flush = 1'b0;
    #3 i_reset = 1'b1;
    load_lw5();
    drive(ADD, 5'd7, 5'd8, 5'd9, 1'b1, 32'h1234, 32'h104);
    i_reset = 1'b0;
    #2;
    total++; if (a_bus !== '0) begin bad++; $display("FAIL reset_a_bus: got %h want 0", a_bus); end
    total++; if (b_bus !== '0) begin bad++; $display("FAIL reset_b_bus: got %h want 0", b_bus); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", a_stall); end
    total++; if (a_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", a_cnt); end
    i_reset = 1'b1;
    drive(10'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFF0, 32'h4);
    exp_q.push_back(mk(10'h0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF0, 32'h4));
    tick();
    exp_v = exp_q.pop_front();
    total++; if (a_bus !== exp_v) begin bad++; $display("FAIL reset_release_latch: got %h want %h", a_bus, exp_v); end
  endtask

  task automatic test_load_use_single();
    apply_reset();
    exp_q.push_back(mk(LW, 5'd1, 5'd5, 5'd0, 32'h10, 32'h100));
    load_lw5();
    exp_v = exp_q.pop_front();
    total++; if (a_bus !== exp_v) begin bad++; $display("FAIL lu_lw_latched: got %h want %h", a_bus, exp_v); end
    drive(ADD, 5'd5, 5'd6, 5'd3, 1'b1, 32'h0, 32'h104);
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL lu_stall_high: got %b want 1", a_stall); end
    exp_q.push_back(mk(10'h0, 5'd1, 5'd5, 5'd0, 32'h10, 32'h100));
    tick();
    exp_v = exp_q.pop_front();
    total++; if (a_bus !== exp_v) begin bad++; $display("FAIL lu_bubble: got %h want %h", a_bus, exp_v); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL lu_stall_released: got %b want 0", a_stall); end
    exp_q.push_back(mk(ADD, 5'd5, 5'd6, 5'd3, 32'h0, 32'h104));
    tick();
    exp_v = exp_q.pop_front();
    total++; if (a_bus !== exp_v) begin bad++; $display("FAIL lu_add_latched: got %h want %h", a_bus, exp_v); end
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL lu_count: got %0d want 1", a_cnt); end
  endtask

  task automatic test_multi_stall();
    apply_reset();
    load_lw5();
    drive(ADD, 5'd2, 5'd5, 5'd4, 1'b1, 32'h8, 32'h104);
    for (int k = 0; k < 3; k++) begin
      total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL ms_stall_%0d: got %b want 1", k, b_stall); end
      exp_q.push_back(mk(10'h0, 5'd1, 5'd5, 5'd0, 32'h10, 32'h100));
      tick();
      exp_v = exp_q.pop_front();
      total++; if (b_bus !== exp_v) begin bad++; $display("FAIL ms_bubble_%0d: got %h want %h", k, b_bus, exp_v); end
    end
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL ms_stall_end: got %b want 0", b_stall); end
    exp_q.push_back(mk(ADD, 5'd2, 5'd5, 5'd4, 32'h8, 32'h104));
    tick();
    exp_v = exp_q.pop_front();
    total++; if (b_bus !== exp_v) begin bad++; $display("FAIL ms_add_latched: got %h want %h", b_bus, exp_v); end
    total++; if (b_cnt !== 2'd3) begin bad++; $display("FAIL ms_count: got %0d want 3", b_cnt); end
    // Same rt match but the ID instruction does not read rt.
    apply_reset();
    load_lw5();
    drive(ADD, 5'd2, 5'd5, 5'd4, 1'b0, 32'h8, 32'h104);
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL ms_no_uses_rt_b: got %b want 0", b_stall); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL ms_no_uses_rt_a: got %b want 0", a_stall); end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    load_lw5();
    drive(ADD, 5'd5, 5'd6, 5'd3, 1'b1, 32'h0, 32'h104);
    tick();
    total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL rms_in_stall: got %b want 1", b_stall); end
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL rms_stall_cleared: got %b want 0", b_stall); end
    total++; if (b_bus !== '0) begin bad++; $display("FAIL rms_bus_cleared: got %h want 0", b_bus); end
  endtask

  task automatic test_zero_rt_and_flush();
    apply_reset();
    drive(LW, 5'd1, 5'd0, 5'd0, 1'b0, 32'h10, 32'h100);
    tick();
    drive(ADD, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h104);
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL zero_rt_stall: got %b want 0", a_stall); end
    exp_q.push_back(mk(ADD, 5'd0, 5'd0, 5'd3, 32'h0, 32'h104));
    tick();
    exp_v = exp_q.pop_front();
    total++; if (a_bus !== exp_v) begin bad++; $display("FAIL zero_rt_latched: got %h want %h", a_bus, exp_v); end
    // Hazard coincident with a flush.
    apply_reset();
    load_lw5();
    i_flush = 1'b1;
    drive(ADD, 5'd5, 5'd6, 5'd3, 1'b1, 32'h0, 32'h104);
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", b_stall); end
    exp_q.push_back('0);
    tick();
    exp_v = exp_q.pop_front();
    total++; if (b_bus !== exp_v) begin bad++; $display("FAIL flush_bubble: got %h want %h", b_bus, exp_v); end
    i_flush = 1'b0;
    drive(ADD, 5'd7, 5'd8, 5'd9, 1'b1, 32'h3, 32'h108);
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL flush_fsm_run: got %b want 0", b_stall); end
    exp_q.push_back(mk(ADD, 5'd7, 5'd8, 5'd9, 32'h3, 32'h108));
    tick();
    exp_v = exp_q.pop_front();
    total++; if (b_bus !== exp_v) begin bad++; $display("FAIL flush_next_latched: got %h want %h", b_bus, exp_v); end
  endtask

  task automatic test_enable_freeze();
    apply_reset();
    load_lw5();
    drive(ADD, 5'd5, 5'd6, 5'd3, 1'b1, 32'h0, 32'h104);
    tick();
    i_enable = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL frz_stall_%0d: got %b want 0", k, b_stall); end
      exp_q.push_back(mk(10'h0, 5'd1, 5'd5, 5'd0, 32'h10, 32'h100));
      tick();
      exp_v = exp_q.pop_front();
      total++; if (b_bus !== exp_v) begin bad++; $display("FAIL frz_bus_%0d: got %h want %h", k, b_bus, exp_v); end
      total++; if (b_cnt !== 2'd1) begin bad++; $display("FAIL frz_cnt_%0d: got %0d want 1", k, b_cnt); end
    end
    i_enable = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL frz_resume_%0d: got %b want 1", k, b_stall); end
      tick();
    end
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL frz_resume_end: got %b want 0", b_stall); end
    exp_q.push_back(mk(ADD, 5'd5, 5'd6, 5'd3, 32'h0, 32'h104));
    tick();
    exp_v = exp_q.pop_front();
    total++; if (b_bus !== exp_v) begin bad++; $display("FAIL frz_add_latched: got %h want %h", b_bus, exp_v); end
  endtask

  task automatic test_saturate();
    apply_reset();
    load_lw5();
    drive(ADD, 5'd5, 5'd6, 5'd3, 1'b1, 32'h0, 32'h104);
    repeat (4) tick();
    drive(LW, 5'd9, 5'd5, 5'd0, 1'b0, 32'h20, 32'h108);
    tick();
    drive(ADD, 5'd5, 5'd6, 5'd3, 1'b1, 32'h0, 32'h10C);
    for (int k = 0; k < 3; k++) begin
      total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL sat_stall_%0d: got %b want 1", k, b_stall); end
      tick();
    end
    total++; if (b_cnt !== 2'd3) begin bad++; $display("FAIL sat_count_b: got %0d want 3", b_cnt); end
    total++; if (a_cnt !== 16'd2) begin bad++; $display("FAIL sat_count_a: got %0d want 2", a_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_enable = 1'b1; i_flush = 1'b0;
    drive(10'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_load_use_single();
    test_multi_stall();
    test_reset_mid_stall();
    test_zero_rt_and_flush();
    test_enable_freeze();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
